nvdla_noc_axi_write_responder: RTL and testbench
================================================

Name: nvdla_noc_axi_write_responder

Overview:
- AXI write-slave endpoint on the NOC side of the MCIF write path.
- Accepts AW bursts and W beats from the MCIF write initiator and retires each beat to a flat memory write port.
- Returns one B response per burst, carrying the burst's awid as bid, after a programmable delay.
- Used as the memory-side responder in subsystem sims and FPGA bring-up; tracks outstanding writes.

Parameters:
AW_DEPTH, 8, AW command FIFO entries (power of 2, 2..16)
B_DEPTH, 8, pending-response FIFO entries (power of 2, 2..16)
RSP_DELAY, 4, cycles a B entry must sit at the B FIFO head before bvalid asserts (0..15)

Ports:
nvdla_core_clk  in  1  core clock
nvdla_core_rstn  in  1  async active-low reset
mcif2noc_axi_aw_awvalid  in  1  AW valid
mcif2noc_axi_aw_awready  out  1  AW ready
mcif2noc_axi_aw_awid  in  8  burst ID
mcif2noc_axi_aw_awlen  in  4  beats minus 1
mcif2noc_axi_aw_awaddr  in  64  burst start byte address, 64B aligned
mcif2noc_axi_w_wvalid  in  1  W valid
mcif2noc_axi_w_wready  out  1  W ready
mcif2noc_axi_w_wdata  in  512  beat data
mcif2noc_axi_w_wstrb  in  64  byte enables
mcif2noc_axi_w_wlast  in  1  last beat flag
noc2mcif_axi_b_bvalid  out  1  B valid
noc2mcif_axi_b_bready  in  1  B ready
noc2mcif_axi_b_bid  out  8  response ID
mem_wr_en  out  1  memory write strobe
mem_wr_ready  in  1  memory can accept a write this cycle
mem_wr_addr  out  64  beat byte address
mem_wr_data  out  512  beat data
mem_wr_strb  out  64  beat byte enables
wr_os_cnt  out  8  bursts accepted on AW and not yet completed on B
err_wlast  out  1  sticky wlast-mismatch flag

Behaviour:
- Reset values (async assert, sync release): awready 1 (AW FIFO empty), wready 0, bvalid 0, bid 0, mem_wr_en 0, wr_os_cnt 0, err_wlast 0, beat_cnt 0, both FIFOs empty, delay counter 0.
- AW:
  - awready = !aw_full; no pop-bypass when full.
  - Handshake pushes {id, len, addr} into the AW FIFO.
- W:
  - Beats always belong to the AW FIFO head; W never runs ahead of AW.
  - wready = aw_head_vld && mem_wr_ready && (!last_beat || !b_full).
  - last_beat = (beat_cnt == head_len).
- Memory port, combinational from the W handshake:
  - mem_wr_en = wvalid && wready; zero added latency.
  - mem_wr_addr = head_addr + {beat_cnt, 6'b0}, 64-bit add with wrap.
  - mem_wr_data = wdata; mem_wr_strb = wstrb.
- Beat counter, on each W handshake:
  - not last_beat: beat_cnt++.
  - last_beat: beat_cnt <= 0, pop AW head, push head_id into the B FIFO.
  - Burst end is decided solely by beat_cnt vs len; wlast is only checked.
- B FIFO and delay:
  - dly_cnt resets to 0 whenever the head changes or the FIFO is empty; otherwise it increments, saturating at RSP_DELAY.
  - bvalid = b_head_vld && (dly_cnt == RSP_DELAY); bid = b_head_id.
  - bvalid and bid stay stable until bready.
  - B handshake pops the head; the next entry restarts its delay at 0.
  - RSP_DELAY = 0: bvalid the cycle after the push.
- wr_os_cnt:
  - +1 on AW handshake, -1 on B handshake, unchanged when both occur in the same cycle.
  - Never exceeds AW_DEPTH + B_DEPTH.
- Simultaneous events:
  - AW push and pop in the same cycle: occupancy unchanged.
  - B push and pop in the same cycle: allowed, since b_full is evaluated before the pop.
  - Last beat while B is full: stalls via wready = 0.
- Reset mid-burst: all state is discarded; no partial B is issued after reset.

Optional Feature:
- Macro: NVDLA_NOC_WR_RSP_WLAST_CHK_EN
- Defined: on every W handshake, compare wlast with last_beat; on mismatch err_wlast sets to 1 and stays 1 until reset. Data is still written and the burst still ends on the count.
- Undefined: no compare logic; err_wlast is tied to 0.

Test Plan:
- AW id=0x12 len=0 addr=0x1000, one W beat with wlast=1; mem_wr_ready=1, bready=1, RSP_DELAY=4 -> one mem_wr_en at addr 0x1000; bvalid 5 cycles after the W handshake with bid=0x12; wr_os_cnt goes 1 then 0.
- AW len=3 addr=0x2000 with 4 beats -> mem_wr_addr 0x2000, 0x2040, 0x2080, 0x20C0; a single B.
- Two bursts (ids 0x01, 0x02) completed back-to-back, bready held 0 for 10 cycles -> bvalid/bid=0x01 held stable; 0x02 is issued RSP_DELAY cycles after 0x01 is popped.
- AW_DEPTH+1 AW requests with no W traffic -> awready drops to 0 after 8 handshakes; wr_os_cnt=8.
- With the macro defined, burst len=1 sent with wlast=1 on beat 0 -> err_wlast=1 from the next cycle; 2 beats written; one B.
- Reset asserted after beat 1 of a len=3 burst -> all outputs at reset values; a new len=0 burst completes normally afterwards.

Source files
------------

// File: rtl/nvdla_noc_axi_write_responder.sv
// nvdla_noc_axi_write_responder
// -----------------------------------------------------------------------------
// AXI write-slave endpoint on the NOC side of the MCIF write path. AW bursts are
// queued in a command FIFO. W beats are retired one per handshake to a flat
// memory write port at the address of the AW FIFO head. When a burst's last
// beat (by count) retires, its id moves to a pending-response FIFO. That FIFO's
// head is answered on B after it has sat at the head for RSP_DELAY cycles.
//
// Optional build macro: NVDLA_NOC_WR_RSP_WLAST_CHK_EN
//   When defined, a sticky err_wlast flag records any W handshake where wlast
//   disagrees with the beat count. When undefined, err_wlast is tied to 0.
//
// Ports
//   nvdla_core_clk / nvdla_core_rstn : clock, async active-low reset
//   mcif2noc_axi_aw_*                : AW channel (valid/ready, id, len, addr)
//   mcif2noc_axi_w_*                 : W channel (valid/ready, data, strb, last)
//   noc2mcif_axi_b_*                 : B channel (valid/ready, id)
//   mem_wr_*                         : memory write port, mem_wr_ready is backpressure
//   wr_os_cnt                        : bursts accepted on AW and not yet retired on B
//   err_wlast                        : sticky wlast-mismatch flag
//
// Handshake rule for every channel: a transfer happens on a rising clock edge
// where valid && ready. Once valid is raised by the source, it and its payload
// hold steady until that edge. Ready may depend on state and on the other
// side's inputs, but never on the valid of the same channel.
// -----------------------------------------------------------------------------
module nvdla_noc_axi_write_responder #(
  parameter int AW_DEPTH  = 8,
  parameter int B_DEPTH   = 8,
  parameter int RSP_DELAY = 4
) (
  input  logic         nvdla_core_clk,
  input  logic         nvdla_core_rstn,
  input  logic         mcif2noc_axi_aw_awvalid,
  output logic         mcif2noc_axi_aw_awready,
  input  logic [7:0]   mcif2noc_axi_aw_awid,
  input  logic [3:0]   mcif2noc_axi_aw_awlen,
  input  logic [63:0]  mcif2noc_axi_aw_awaddr,
  input  logic         mcif2noc_axi_w_wvalid,
  output logic         mcif2noc_axi_w_wready,
  input  logic [511:0] mcif2noc_axi_w_wdata,
  input  logic [63:0]  mcif2noc_axi_w_wstrb,
  input  logic         mcif2noc_axi_w_wlast,
  output logic         noc2mcif_axi_b_bvalid,
  input  logic         noc2mcif_axi_b_bready,
  output logic [7:0]   noc2mcif_axi_b_bid,
  output logic         mem_wr_en,
  input  logic         mem_wr_ready,
  output logic [63:0]  mem_wr_addr,
  output logic [511:0] mem_wr_data,
  output logic [63:0]  mem_wr_strb,
  output logic [7:0]   wr_os_cnt,
  output logic         err_wlast
);

  localparam int AW_PW = $clog2(AW_DEPTH);
  localparam int B_PW  = $clog2(B_DEPTH);
  localparam logic [AW_PW:0] AW_FULL_CNT = (AW_PW+1)'(AW_DEPTH);
  localparam logic [B_PW:0]  B_FULL_CNT  = (B_PW+1)'(B_DEPTH);
  localparam logic [3:0]     DLY_MAX     = 4'(RSP_DELAY);

  typedef struct packed {
    logic [7:0]  id;
    logic [3:0]  len;
    logic [63:0] addr;
  } aw_cmd_t;

  // FIFO storage (no reset needed: occupancy counters gate every read)
  aw_cmd_t          aw_mem [AW_DEPTH];
  logic [7:0]       b_mem  [B_DEPTH];

  logic [AW_PW-1:0] aw_wr_ptr, aw_rd_ptr;
  logic [AW_PW:0]   aw_cnt;
  logic [B_PW-1:0]  b_wr_ptr, b_rd_ptr;
  logic [B_PW:0]    b_cnt;
  logic [3:0]       beat_cnt;
  logic [3:0]       dly_cnt;
  logic [7:0]       os_cnt;

  aw_cmd_t aw_head;
  logic    aw_head_vld, aw_full, b_head_vld, b_full;
  logic    last_beat, aw_hs, w_hs, last_hs, b_hs;

  assign aw_head_vld = (aw_cnt != '0);
  assign aw_full     = (aw_cnt == AW_FULL_CNT);
  assign b_head_vld  = (b_cnt != '0);
  assign b_full      = (b_cnt == B_FULL_CNT);
  assign aw_head     = aw_mem[aw_rd_ptr];

  // Burst end is decided by the count alone; wlast is never trusted.
  assign last_beat = (beat_cnt == aw_head.len);

  assign mcif2noc_axi_aw_awready = !aw_full;
  // A last beat needs a free B slot. b_full is the pre-pop occupancy, so a
  // same-cycle B pop does not open the slot early.
  assign mcif2noc_axi_w_wready   = aw_head_vld && mem_wr_ready && (!last_beat || !b_full);

  assign aw_hs   = mcif2noc_axi_aw_awvalid && mcif2noc_axi_aw_awready;
  assign w_hs    = mcif2noc_axi_w_wvalid && mcif2noc_axi_w_wready;
  assign last_hs = w_hs && last_beat;
  assign b_hs    = noc2mcif_axi_b_bvalid && noc2mcif_axi_b_bready;

  // Memory port follows the W handshake with zero added latency.
  assign mem_wr_en   = w_hs;
  assign mem_wr_addr = aw_head.addr + {54'd0, beat_cnt, 6'd0};
  assign mem_wr_data = mcif2noc_axi_w_wdata;
  assign mem_wr_strb = mcif2noc_axi_w_wstrb;

  // The B head only changes on a pop, and dly_cnt saturates. Together these
  // keep bvalid and bid stable until bready.
  assign noc2mcif_axi_b_bvalid = b_head_vld && (dly_cnt == DLY_MAX);
  assign noc2mcif_axi_b_bid    = b_head_vld ? b_mem[b_rd_ptr] : 8'h00;
  assign wr_os_cnt             = os_cnt;

  always_ff @(posedge nvdla_core_clk) begin
    if (aw_hs) begin
      aw_mem[aw_wr_ptr] <= {mcif2noc_axi_aw_awid, mcif2noc_axi_aw_awlen, mcif2noc_axi_aw_awaddr};
    end
    if (last_hs) begin
      b_mem[b_wr_ptr] <= aw_head.id;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      aw_wr_ptr <= '0;
      aw_rd_ptr <= '0;
      aw_cnt    <= '0;
      b_wr_ptr  <= '0;
      b_rd_ptr  <= '0;
      b_cnt     <= '0;
      beat_cnt  <= 4'd0;
      dly_cnt   <= 4'd0;
      os_cnt    <= 8'd0;
    end else begin
      // AW command FIFO
      if (aw_hs)   aw_wr_ptr <= aw_wr_ptr + AW_PW'(1);
      if (last_hs) aw_rd_ptr <= aw_rd_ptr + AW_PW'(1);
      if (aw_hs && !last_hs)      aw_cnt <= aw_cnt + (AW_PW+1)'(1);
      else if (!aw_hs && last_hs) aw_cnt <= aw_cnt - (AW_PW+1)'(1);

      // Beat counter within the head burst
      if (w_hs) beat_cnt <= last_beat ? 4'd0 : beat_cnt + 4'd1;

      // Pending-response FIFO
      if (last_hs) b_wr_ptr <= b_wr_ptr + B_PW'(1);
      if (b_hs)    b_rd_ptr <= b_rd_ptr + B_PW'(1);
      if (last_hs && !b_hs)      b_cnt <= b_cnt + (B_PW+1)'(1);
      else if (!last_hs && b_hs) b_cnt <= b_cnt - (B_PW+1)'(1);

      // Response delay: restart on every head change (pop, or push into empty)
      if (b_hs || !b_head_vld)   dly_cnt <= 4'd0;
      else if (dly_cnt != DLY_MAX) dly_cnt <= dly_cnt + 4'd1;

      // Outstanding bursts
      if (aw_hs && !b_hs)      os_cnt <= os_cnt + 8'd1;
      else if (!aw_hs && b_hs) os_cnt <= os_cnt - 8'd1;
    end
  end

`ifdef NVDLA_NOC_WR_RSP_WLAST_CHK_EN
  logic err_wlast_q;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      err_wlast_q <= 1'b0;
    end else if (w_hs && (mcif2noc_axi_w_wlast != last_beat)) begin
      err_wlast_q <= 1'b1;
    end
  end

  assign err_wlast = err_wlast_q;
`else
  logic unused_wlast;
  assign unused_wlast = mcif2noc_axi_w_wlast;
  assign err_wlast    = 1'b0;
`endif

endmodule

// File: tb/tb_nvdla_noc_axi_write_responder.sv
// Directed testbench for nvdla_noc_axi_write_responder (default parameters).
module tb_nvdla_noc_axi_write_responder;

  localparam int RSP_DELAY = 4;
`ifdef NVDLA_NOC_WR_RSP_WLAST_CHK_EN
  localparam logic [63:0] EXP_ERR = 64'd1;
`else
  localparam logic [63:0] EXP_ERR = 64'd0;
`endif

  // ---------------- clock / reset ----------------
  logic         nvdla_core_clk = 1'b0;
  logic         nvdla_core_rstn;
  logic         mcif2noc_axi_aw_awvalid;
  logic         mcif2noc_axi_aw_awready;
  logic [7:0]   mcif2noc_axi_aw_awid;
  logic [3:0]   mcif2noc_axi_aw_awlen;
  logic [63:0]  mcif2noc_axi_aw_awaddr;
  logic         mcif2noc_axi_w_wvalid;
  logic         mcif2noc_axi_w_wready;
  logic [511:0] mcif2noc_axi_w_wdata;
  logic [63:0]  mcif2noc_axi_w_wstrb;
  logic         mcif2noc_axi_w_wlast;
  logic         noc2mcif_axi_b_bvalid;
  logic         noc2mcif_axi_b_bready;
  logic [7:0]   noc2mcif_axi_b_bid;
  logic         mem_wr_en;
  logic         mem_wr_ready;
  logic [63:0]  mem_wr_addr;
  logic [511:0] mem_wr_data;
  logic [63:0]  mem_wr_strb;
  logic [7:0]   wr_os_cnt;
  logic         err_wlast;

  always #5 nvdla_core_clk = ~nvdla_core_clk;

  nvdla_noc_axi_write_responder #(
    .AW_DEPTH(8), .B_DEPTH(8), .RSP_DELAY(RSP_DELAY)
  ) dut (
    .nvdla_core_clk          (nvdla_core_clk),
    .nvdla_core_rstn         (nvdla_core_rstn),
    .mcif2noc_axi_aw_awvalid (mcif2noc_axi_aw_awvalid),
    .mcif2noc_axi_aw_awready (mcif2noc_axi_aw_awready),
    .mcif2noc_axi_aw_awid    (mcif2noc_axi_aw_awid),
    .mcif2noc_axi_aw_awlen   (mcif2noc_axi_aw_awlen),
    .mcif2noc_axi_aw_awaddr  (mcif2noc_axi_aw_awaddr),
    .mcif2noc_axi_w_wvalid   (mcif2noc_axi_w_wvalid),
    .mcif2noc_axi_w_wready   (mcif2noc_axi_w_wready),
    .mcif2noc_axi_w_wdata    (mcif2noc_axi_w_wdata),
    .mcif2noc_axi_w_wstrb    (mcif2noc_axi_w_wstrb),
    .mcif2noc_axi_w_wlast    (mcif2noc_axi_w_wlast),
    .noc2mcif_axi_b_bvalid   (noc2mcif_axi_b_bvalid),
    .noc2mcif_axi_b_bready   (noc2mcif_axi_b_bready),
    .noc2mcif_axi_b_bid      (noc2mcif_axi_b_bid),
    .mem_wr_en               (mem_wr_en),
    .mem_wr_ready            (mem_wr_ready),
    .mem_wr_addr             (mem_wr_addr),
    .mem_wr_data             (mem_wr_data),
    .mem_wr_strb             (mem_wr_strb),
    .wr_os_cnt               (wr_os_cnt),
    .err_wlast               (err_wlast)
  );

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_fail = 0;
  int n_wr   = 0;
  int n_b    = 0;
  logic [63:0]  exp_q[$];    // expected memory write addresses, in order
  logic [511:0] exp_d_q[$];  // expected memory write data, in order
  logic [7:0]   exp_b_q[$];  // expected B ids, in order

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] pat(input logic [63:0] a);
    return {8{a ^ 64'hA5A5_5A5A_0F0F_F0F0}};
  endfunction

  task automatic expect_beat(input logic [63:0] a);
    exp_q.push_back(a);
    exp_d_q.push_back(pat(a));
  endtask

  // Scoreboard: every memory write and every B handshake is matched in order.
  always @(negedge nvdla_core_clk) begin
    if (nvdla_core_rstn && mem_wr_en) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        check("mem_wr_unexpected", 64'(mem_wr_en), 64'd0);
      end else begin
        check("mem_wr_addr", mem_wr_addr, exp_q.pop_front());
        check("mem_wr_strb", mem_wr_strb, mcif2noc_axi_w_wstrb);
        n_chk++;
        assert (mem_wr_data === exp_d_q.pop_front()) else begin
          n_fail++;
          $error("FAIL mem_wr_data: observed 0x%0h", mem_wr_data);
        end
      end
    end
    if (nvdla_core_rstn && noc2mcif_axi_b_bvalid && noc2mcif_axi_b_bready) begin
      n_b++;
      if (exp_b_q.size() == 0) check("b_unexpected", 64'(noc2mcif_axi_b_bvalid), 64'd0);
      else check("bid", 64'(noc2mcif_axi_b_bid), 64'(exp_b_q.pop_front()));
    end
  end

  // ---------------- driver tasks (called just after a rising edge) ----------------
  task automatic step();
    @(posedge nvdla_core_clk);
    #1;
  endtask

  task automatic send_aw(input logic [7:0] id, input logic [3:0] len, input logic [63:0] addr);
    int n;
    n = 0;
    mcif2noc_axi_aw_awvalid = 1'b1;
    mcif2noc_axi_aw_awid    = id;
    mcif2noc_axi_aw_awlen   = len;
    mcif2noc_axi_aw_awaddr  = addr;
    @(negedge nvdla_core_clk);
    while (!mcif2noc_axi_aw_awready && n < 200) begin
      @(negedge nvdla_core_clk);
      n++;
    end
    check("aw_accept", 64'(mcif2noc_axi_aw_awready), 64'd1);
    step();
    mcif2noc_axi_aw_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] a, input logic last);
    int n;
    n = 0;
    mcif2noc_axi_w_wvalid = 1'b1;
    mcif2noc_axi_w_wdata  = pat(a);
    mcif2noc_axi_w_wstrb  = ~a;
    mcif2noc_axi_w_wlast  = last;
    @(negedge nvdla_core_clk);
    while (!mcif2noc_axi_w_wready && n < 200) begin
      @(negedge nvdla_core_clk);
      n++;
    end
    check("w_accept", 64'(mcif2noc_axi_w_wready), 64'd1);
    step();
    mcif2noc_axi_w_wvalid = 1'b0;
  endtask

  task automatic wait_bvalid(output int n);
    n = 0;
    do begin
      @(negedge nvdla_core_clk);
      n++;
    end while (!noc2mcif_axi_b_bvalid && n < 100);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_awready"}, 64'(mcif2noc_axi_aw_awready), 64'd1);
    check({pfx, "_wready"},  64'(mcif2noc_axi_w_wready),   64'd0);
    check({pfx, "_bvalid"},  64'(noc2mcif_axi_b_bvalid),   64'd0);
    check({pfx, "_bid"},     64'(noc2mcif_axi_b_bid),      64'd0);
    check({pfx, "_mem_wr"},  64'(mem_wr_en),               64'd0);
    check({pfx, "_os_cnt"},  64'(wr_os_cnt),               64'd0);
    check({pfx, "_err"},     64'(err_wlast),               64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n, wr0, b0;
    nvdla_core_rstn         = 1'b0;
    mcif2noc_axi_aw_awvalid = 1'b0;
    mcif2noc_axi_aw_awid    = 8'h00;
    mcif2noc_axi_aw_awlen   = 4'd0;
    mcif2noc_axi_aw_awaddr  = 64'd0;
    mcif2noc_axi_w_wvalid   = 1'b0;
    mcif2noc_axi_w_wdata    = '0;
    mcif2noc_axi_w_wstrb    = 64'd0;
    mcif2noc_axi_w_wlast    = 1'b0;
    noc2mcif_axi_b_bready   = 1'b1;
    mem_wr_ready            = 1'b1;

    repeat (3) @(posedge nvdla_core_clk);
    @(negedge nvdla_core_clk);
    check_reset_outputs("rst");
    step();
    nvdla_core_rstn = 1'b1;
    step();

    // 1: single-beat burst, B arrives RSP_DELAY+1 cycles after the W handshake
    wr0 = n_wr; b0 = n_b;
    expect_beat(64'h1000);
    exp_b_q.push_back(8'h12);
    send_aw(8'h12, 4'd0, 64'h1000);
    @(negedge nvdla_core_clk);
    check("t1_os_after_aw", 64'(wr_os_cnt), 64'd1);
    step();
    send_w(64'h1000, 1'b1);
    wait_bvalid(n);
    check("t1_b_latency", 64'(n), 64'(RSP_DELAY + 1));
    check("t1_os_before_b", 64'(wr_os_cnt), 64'd1);
    step();
    @(negedge nvdla_core_clk);
    check("t1_os_after_b", 64'(wr_os_cnt), 64'd0);
    check("t1_bvalid_low", 64'(noc2mcif_axi_b_bvalid), 64'd0);
    check("t1_writes", 64'(n_wr - wr0), 64'd1);
    check("t1_bs", 64'(n_b - b0), 64'd1);
    step();

    // 2: four-beat burst with a memory backpressure stall on beat 2
    wr0 = n_wr; b0 = n_b;
    expect_beat(64'h2000); expect_beat(64'h2040);
    expect_beat(64'h2080); expect_beat(64'h20C0);
    exp_b_q.push_back(8'h34);
    send_aw(8'h34, 4'd3, 64'h2000);
    send_w(64'h2000, 1'b0);
    send_w(64'h2040, 1'b0);
    mem_wr_ready          = 1'b0;
    mcif2noc_axi_w_wvalid = 1'b1;
    @(negedge nvdla_core_clk);
    check("t2_stall_wready", 64'(mcif2noc_axi_w_wready), 64'd0);
    check("t2_stall_mem_wr", 64'(mem_wr_en), 64'd0);
    step();
    mem_wr_ready = 1'b1;
    send_w(64'h2080, 1'b0);
    send_w(64'h20C0, 1'b1);
    wait_bvalid(n);
    check("t2_b_latency", 64'(n), 64'(RSP_DELAY + 1));
    step();
    check("t2_writes", 64'(n_wr - wr0), 64'd4);
    check("t2_bs", 64'(n_b - b0), 64'd1);

    // 3: two responses queued while bready is low; head holds steady
    noc2mcif_axi_b_bready = 1'b0;
    expect_beat(64'h3000); expect_beat(64'h3040);
    exp_b_q.push_back(8'h01); exp_b_q.push_back(8'h02);
    send_aw(8'h01, 4'd0, 64'h3000);
    send_aw(8'h02, 4'd0, 64'h3040);
    send_w(64'h3000, 1'b1);
    send_w(64'h3040, 1'b1);
    wait_bvalid(n);
    check("t3_bvalid_up", 64'(noc2mcif_axi_b_bvalid), 64'd1);
    check("t3_os_two", 64'(wr_os_cnt), 64'd2);
    for (int i = 0; i < 10; i++) begin
      @(negedge nvdla_core_clk);
      check("t3_hold", 64'({noc2mcif_axi_b_bvalid, noc2mcif_axi_b_bid}), 64'h101);
    end
    step();
    noc2mcif_axi_b_bready = 1'b1;
    step();  // 0x01 pops on this edge; 0x02 restarts its delay from 0
    wait_bvalid(n);
    check("t3_second_latency", 64'(n), 64'(RSP_DELAY + 1));
    check("t3_second_bid", 64'(noc2mcif_axi_b_bid), 64'h02);
    step();
    @(negedge nvdla_core_clk);
    check("t3_os_zero", 64'(wr_os_cnt), 64'd0);
    step();

    // 4: fill the AW FIFO, then the B FIFO, then stall a last beat on B full
    noc2mcif_axi_b_bready = 1'b0;
    b0 = n_b;
    for (int i = 0; i < 8; i++) begin
      expect_beat(64'h4000 + 64'(i) * 64'h40);
      exp_b_q.push_back(8'h40 + 8'(i));
      send_aw(8'h40 + 8'(i), 4'd0, 64'h4000 + 64'(i) * 64'h40);
    end
    @(negedge nvdla_core_clk);
    check("t4_aw_full", 64'(mcif2noc_axi_aw_awready), 64'd0);
    check("t4_os_eight", 64'(wr_os_cnt), 64'd8);
    step();
    mcif2noc_axi_aw_awvalid = 1'b1;
    mcif2noc_axi_aw_awid    = 8'h48;
    mcif2noc_axi_aw_awlen   = 4'd0;
    mcif2noc_axi_aw_awaddr  = 64'h4200;
    repeat (3) begin
      @(negedge nvdla_core_clk);
      check("t4_aw_blocked", 64'({mcif2noc_axi_aw_awready, wr_os_cnt}), 64'h008);
    end
    step();
    mcif2noc_axi_aw_awvalid = 1'b0;
    for (int i = 0; i < 8; i++) send_w(64'h4000 + 64'(i) * 64'h40, 1'b1);
    @(negedge nvdla_core_clk);
    check("t4_os_in_b", 64'(wr_os_cnt), 64'd8);
    check("t4_b_head", 64'({noc2mcif_axi_b_bvalid, noc2mcif_axi_b_bid}), 64'h140);
    step();
    expect_beat(64'h4200);
    exp_b_q.push_back(8'h48);
    send_aw(8'h48, 4'd0, 64'h4200);
    @(negedge nvdla_core_clk);
    check("t4_os_nine", 64'(wr_os_cnt), 64'd9);
    step();
    mcif2noc_axi_w_wvalid = 1'b1;
    mcif2noc_axi_w_wdata  = pat(64'h4200);
    mcif2noc_axi_w_wstrb  = ~64'h4200;
    mcif2noc_axi_w_wlast  = 1'b1;
    @(negedge nvdla_core_clk);
    check("t4_bfull_wready", 64'(mcif2noc_axi_w_wready), 64'd0);
    check("t4_bfull_mem_wr", 64'(mem_wr_en), 64'd0);
    step();
    noc2mcif_axi_b_bready = 1'b1;
    send_w(64'h4200, 1'b1);
    n = 0;
    do begin
      @(negedge nvdla_core_clk);
      n++;
    end while (wr_os_cnt != 8'd0 && n < 300);
    check("t4_os_drained", 64'(wr_os_cnt), 64'd0);
    check("t4_bs", 64'(n_b - b0), 64'd9);
    step();

    // 5: wlast on the wrong beat; burst still ends on the count
    wr0 = n_wr; b0 = n_b;
    expect_beat(64'h5000); expect_beat(64'h5040);
    exp_b_q.push_back(8'h55);
    send_aw(8'h55, 4'd1, 64'h5000);
    send_w(64'h5000, 1'b1);
    @(negedge nvdla_core_clk);
    check("t5_err_set", 64'(err_wlast), EXP_ERR);
    step();
    send_w(64'h5040, 1'b1);
    wait_bvalid(n);
    check("t5_b_latency", 64'(n), 64'(RSP_DELAY + 1));
    step();
    check("t5_err_sticky", 64'(err_wlast), EXP_ERR);
    check("t5_writes", 64'(n_wr - wr0), 64'd2);
    check("t5_bs", 64'(n_b - b0), 64'd1);

    // 6: reset in the middle of a burst, then a clean burst
    expect_beat(64'h6000); expect_beat(64'h6040);
    send_aw(8'h66, 4'd3, 64'h6000);
    send_w(64'h6000, 1'b0);
    send_w(64'h6040, 1'b0);
    nvdla_core_rstn = 1'b0;
    @(negedge nvdla_core_clk);
    check_reset_outputs("mid_rst");
    step();
    nvdla_core_rstn = 1'b1;
    repeat (10) step();
    check("t6_no_stale_b", 64'(noc2mcif_axi_b_bvalid), 64'd0);
    wr0 = n_wr; b0 = n_b;
    expect_beat(64'h7000);
    exp_b_q.push_back(8'h77);
    send_aw(8'h77, 4'd0, 64'h7000);
    send_w(64'h7000, 1'b1);
    wait_bvalid(n);
    check("t6_b_latency", 64'(n), 64'(RSP_DELAY + 1));
    step();
    @(negedge nvdla_core_clk);
    check("t6_os_zero", 64'(wr_os_cnt), 64'd0);
    check("t6_writes", 64'(n_wr - wr0), 64'd1);
    check("t6_bs", 64'(n_b - b0), 64'd1);

    // final report
    check("left_mem_writes", 64'(exp_q.size()), 64'd0);
    check("left_b", 64'(exp_b_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
